i_decode: RTL and testbench
===========================

I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 SHALL have parameter WORD, default 64, register/data width.
REQ-002 SHALL have parameter INSTR_LEN, default 32, instruction width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port instr, input, INSTR_LEN, current LEGv8 instruction.
REQ-007 SHALL have port write_data, input, WORD, write-back value.
REQ-008 SHALL have port read_data1, output, WORD, register[instr[9:5]].
REQ-009 SHALL have port read_data2, output, WORD, register[reg2 address].
REQ-010 SHALL have ports uncondbranch, branch, mem_read, mem_to_reg, mem_write and alu_src, each output, 1, datapath control.
REQ-011 SHALL have port alu_op, output, 2, ALU class.
REQ-012 SHALL have port ext_addr, output, WORD, sign-extended immediate.
REQ-013 SHALL have port alu_con_instr, output, 11, instr[31:21] passthrough.

Function
REQ-014 SHALL contain 32 x WORD registers; X31 (XZR) SHALL always read 0.
REQ-015 SHALL perform reads combinationally from the current instr and register contents, with no write bypass.
REQ-016 SHALL take the reg2 address from instr[20:16] when reg2loc=0 and from instr[4:0] when reg2loc=1.
REQ-017 SHALL, on a rising clk edge with reg_write=1 and reset=0, write write_data to register instr[4:0]; writes to X31 SHALL be discarded.
REQ-018 SHALL keep reg_write and reg2loc internal.
REQ-019 SHALL decode instr[31:21] into controls as {reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncondbranch, alu_op}:
- R-type, 10001011000 ADD / 11001011000 SUB / 10001010000 AND / 10101010000 ORR: 0,0,0,1,0,0,0,0,10.
- LDUR 11111000010: 0,1,1,1,1,0,0,0,00.
- STUR 11111000000: 1,1,0,0,0,1,0,0,00.
- CBZ 10110100xxx: 1,0,0,0,0,0,1,0,01.
- B 000101xxxxx: 0,0,0,0,0,0,0,1,00.
- Any other opcode: all controls 0, alu_op 00, no register write.
REQ-020 SHALL produce ext_addr by sign-extending to WORD:
- D-type: instr[20:12].
- CBZ: instr[23:5].
- B: instr[25:0].
- Otherwise: 0.
REQ-021 SHALL make controls, ext_addr and alu_con_instr purely combinational from instr, with zero latency.
REQ-022 SHALL ignore write_data whenever reg_write=0.

Reset
REQ-023 SHALL clear all 32 registers to 0 on any rising clk edge while reset=1.
REQ-024 SHALL give reset priority over a simultaneous write.
REQ-025 SHALL keep decode outputs combinational and unaffected by reset; read_data1/2 SHALL read 0 after reset.
REQ-026 SHALL resume normal operation on the first edge after reset deasserts; reset asserted mid-sequence SHALL lose all prior writes.

Verification
REQ-027 SHALL cover reset then LDUR: reset, instr=F84402C9 -> mem_read=1, mem_to_reg=1, alu_src=1, alu_op=00, ext_addr=64, read_data1=X22=0; write_data=20 then edge -> X9=20.
REQ-028 SHALL cover R-type ADD: instr=8B09026A after the above -> alu_op=10, alu_src=0, read_data2=20 (X9), alu_con_instr=10001011000; write_data=30 then edge -> X10=30.
REQ-029 SHALL cover STUR: instr=F80602CB -> mem_write=1, alu_src=1, ext_addr=96, read_data2=X11; edge with write_data=0 -> no register changes.
REQ-030 SHALL cover CBZ: instr=B4FFFF6B -> branch=1, alu_op=01, ext_addr=0xFFFFFFFFFFFFFFFB (-5), read_data2=X11; instr=B4000109 -> ext_addr=8, read_data2=X9=20.
REQ-031 SHALL cover B: instr=14000040 -> uncondbranch=1, ext_addr=64; instr=17FFFFC9 -> ext_addr=-55; no register writes.
REQ-032 SHALL cover ORR/AND and XZR: instr=AA150149 -> read_data1=X10=30, read_data2=X21; instr with Rd=31 and write_data=14 -> X31 still reads 0; reset asserted together with a write -> all registers 0.

Source files
------------

// File: rtl/i_decode.sv
// i_decode: LEGv8 instruction-decode stage.
//   Decodes the opcode field into datapath controls, sign-extends the
//   immediate for D-type, CBZ and B formats, and holds the 32-entry register
//   file. X31 is the zero register: it always reads as 0 and ignores writes.
//
// Ports:
//   clk            in   rising-edge clock for the register file
//   reset          in   synchronous active-high reset, clears all registers
//   instr          in   current instruction (INSTR_LEN bits)
//   write_data     in   write-back value, stored at instr[4:0] when reg_write
//   read_data1     out  register[instr[9:5]]
//   read_data2     out  register[instr[4:0]] if reg2loc else register[instr[20:16]]
//   uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src  out  controls
//   alu_op         out  ALU class (00 add, 01 pass/compare, 10 R-type)
//   ext_addr       out  sign-extended immediate
//   alu_con_instr  out  instr[31:21], the ALU-control opcode field
module i_decode #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic [WORD-1:0]      write_data,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic                 uncondbranch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic [WORD-1:0]      ext_addr,
  output logic [10:0]          alu_con_instr
);

  localparam logic [4:0] XZR = 5'd31;

  logic [10:0]     opcode;
  logic            reg2loc;
  logic            reg_write;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      wr_addr;
  logic [WORD-1:0] regs_q [32];
  logic [WORD-1:0] regs_d [32];

  assign opcode        = instr[31:21];
  assign alu_con_instr = opcode;
  assign rs1_addr      = instr[9:5];
  assign rs2_addr      = reg2loc ? instr[4:0] : instr[20:16];
  assign wr_addr       = instr[4:0];

  // Opcode decode and immediate extraction, purely combinational.
  always_comb begin
    reg2loc      = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    uncondbranch = 1'b0;
    alu_op       = 2'b00;
    ext_addr     = '0;
    casez (opcode)
      11'b10001011000,   // ADD
      11'b11001011000,   // SUB
      11'b10001010000,   // AND
      11'b10101010000: begin  // ORR
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      11'b11111000010: begin  // LDUR
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        ext_addr   = {{(WORD-9){instr[20]}}, instr[20:12]};
      end
      11'b11111000000: begin  // STUR: data register comes from Rt field
        reg2loc   = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        ext_addr  = {{(WORD-9){instr[20]}}, instr[20:12]};
      end
      11'b10110100???: begin  // CBZ: tested register comes from Rt field
        reg2loc  = 1'b1;
        branch   = 1'b1;
        alu_op   = 2'b01;
        ext_addr = {{(WORD-19){instr[23]}}, instr[23:5]};
      end
      11'b000101?????: begin  // B
        uncondbranch = 1'b1;
        ext_addr     = {{(WORD-26){instr[25]}}, instr[25:0]};
      end
      default: ;
    endcase
  end

  // Next register-file contents: a single write port, X31 never written.
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (wr_addr != XZR)) begin
      regs_d[wr_addr] = write_data;
    end
  end

  // Reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Asynchronous reads with no write bypass; X31 forced to zero on read.
  assign read_data1 = (rs1_addr == XZR) ? '0 : regs_q[rs1_addr];
  assign read_data2 = (rs2_addr == XZR) ? '0 : regs_q[rs2_addr];

endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: table-driven self-checking bench for i_decode.
//   Each vector occupies one clock cycle: inputs are driven on the falling
//   edge, expected results are queued, and the outputs are popped and compared
//   2 ns later, before the rising edge that commits any register write.
module tb_i_decode;

  localparam int WORD = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  // {uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, alu_op}
  localparam logic [7:0] C_R    = 8'b0000_0010;
  localparam logic [7:0] C_LDUR = 8'b0011_0100;
  localparam logic [7:0] C_STUR = 8'b0000_1100;
  localparam logic [7:0] C_CBZ  = 8'b0100_0001;
  localparam logic [7:0] C_B    = 8'b1000_0000;
  localparam logic [7:0] C_NONE = 8'b0000_0000;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] wdata;
    logic [7:0]  ctrl;
    logic [63:0] ext;
    logic [63:0] rd1;
    logic [63:0] rd2;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [INSTR_LEN-1:0] instr;
  logic [WORD-1:0]      write_data;
  logic [WORD-1:0]      read_data1;
  logic [WORD-1:0]      read_data2;
  logic                 uncondbranch;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_to_reg;
  logic                 mem_write;
  logic                 alu_src;
  logic [1:0]           alu_op;
  logic [WORD-1:0]      ext_addr;
  logic [10:0]          alu_con_instr;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  i_decode #(.WORD(WORD), .INSTR_LEN(INSTR_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .write_data   (write_data),
    .read_data1   (read_data1),
    .read_data2   (read_data2),
    .uncondbranch (uncondbranch),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .ext_addr     (ext_addr),
    .alu_con_instr(alu_con_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] r_ins(logic [10:0] op, logic [4:0] rm,
                                        logic [4:0] rn, logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] d_ins(logic [10:0] op, logic [8:0] imm,
                                        logic [4:0] rn, logic [4:0] rt);
    return {op, imm, 2'b00, rn, rt};
  endfunction

  function automatic vec_t mk(string nm, logic rst, logic [31:0] ins,
                              logic [63:0] wd, logic [7:0] c, logic [63:0] e,
                              logic [63:0] r1, logic [63:0] r2);
    vec_t v;
    v.name = nm; v.rst = rst; v.instr = ins; v.wdata = wd;
    v.ctrl = c; v.ext = e; v.rd1 = r1; v.rd2 = r2;
    return v;
  endfunction

  task automatic chk(string nm, string field, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT now shows.
  task automatic check_out();
    vec_t v;
    logic [7:0] ctrl_act;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: output seen with no expectation queued");
      return;
    end
    v = exp_q.pop_front();
    ctrl_act = {uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, alu_op};
    chk(v.name, "ctrl", 64'(ctrl_act), 64'(v.ctrl));
    chk(v.name, "ext_addr", ext_addr, v.ext);
    chk(v.name, "read_data1", read_data1, v.rd1);
    chk(v.name, "read_data2", read_data2, v.rd2);
    chk(v.name, "alu_con_instr", 64'(alu_con_instr), 64'(v.instr[31:21]));
    $display("vec %-10s rst=%0b instr=%h wd=%0d ctrl=%b ext=%h rd1=%0d rd2=%0d",
             v.name, v.rst, v.instr, v.wdata, ctrl_act, ext_addr, read_data1, read_data2);
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    reset      = v.rst;
    instr      = v.instr;
    write_data = v.wdata;
    exp_q.push_back(v);
    #2;
    check_out();
  endtask

  initial begin
    reset      = 1'b1;
    instr      = '0;
    write_data = '0;
    repeat (2) @(posedge clk);

    // Registers are cleared; decode still works while reset is held, and the
    // LDUR write to X3 that coincides with reset must be dropped.
    apply(mk("rst_ldur", 1'b1, d_ins(OP_LDUR, 9'd1, 5'd3, 5'd3), 64'd777,
             C_LDUR, 64'd1, 64'd0, 64'd0));

    vecs.push_back(mk("ldur", 0, 32'hF84402C9, 64'd20, C_LDUR, 64'd64, 0, 0));
    vecs.push_back(mk("add", 0, 32'h8B09026A, 64'd30, C_R, 0, 0, 64'd20));
    vecs.push_back(mk("stur", 0, 32'hF80602CB, 64'd0, C_STUR, 64'd96, 0, 0));
    vecs.push_back(mk("cbz_neg", 0, 32'hB4FFFF6B, 64'd77, C_CBZ,
                      64'hFFFF_FFFF_FFFF_FFFB, 0, 0));
    vecs.push_back(mk("cbz_pos", 0, 32'hB4000109, 64'd88, C_CBZ, 64'd8, 0, 64'd20));
    vecs.push_back(mk("b_pos", 0, 32'h14000040, 64'd99, C_B, 64'd64, 0, 0));
    vecs.push_back(mk("b_neg", 0, 32'h17FFFFC9, 64'd66, C_B,
                      64'hFFFF_FFFF_FFFF_FFC9, 0, 0));
    vecs.push_back(mk("orr", 0, 32'hAA150149, 64'd5, C_R, 0, 64'd30, 0));
    vecs.push_back(mk("and_xzr", 0, r_ins(OP_AND, 5'd10, 5'd9, 5'd31), 64'd14,
                      C_R, 0, 64'd5, 64'd30));
    vecs.push_back(mk("orr_rdxzr", 0, r_ins(OP_ORR, 5'd9, 5'd31, 5'd31), 64'd0,
                      C_R, 0, 0, 64'd5));
    vecs.push_back(mk("bad_op", 0, r_ins(OP_BAD, 5'd12, 5'd3, 5'd12), 64'd123,
                      C_NONE, 0, 0, 0));
    vecs.push_back(mk("sub", 0, r_ins(OP_SUB, 5'd9, 5'd12, 5'd13), 64'd7,
                      C_R, 0, 0, 64'd5));
    vecs.push_back(mk("ldur_neg", 0, d_ins(OP_LDUR, 9'h100, 5'd13, 5'd14), 64'd55,
                      C_LDUR, 64'hFFFF_FFFF_FFFF_FF00, 64'd7, 0));
    vecs.push_back(mk("add_chk", 0, r_ins(OP_ADD, 5'd13, 5'd14, 5'd31), 64'd0,
                      C_R, 0, 64'd55, 64'd7));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-sequence together with a write: reads still show old values
    // before the edge, then everything (including the new write) is lost.
    apply(mk("rst_mid", 1, r_ins(OP_ADD, 5'd10, 5'd9, 5'd15), 64'd999,
             C_R, 0, 64'd5, 64'd30));
    apply(mk("post_rst", 0, r_ins(OP_ADD, 5'd15, 5'd14, 5'd16), 64'd42,
             C_R, 0, 0, 0));
    apply(mk("resume", 0, r_ins(OP_ORR, 5'd16, 5'd9, 5'd31), 64'd0,
             C_R, 0, 0, 64'd42));
    apply(mk("cleared", 0, r_ins(OP_AND, 5'd13, 5'd10, 5'd31), 64'd0,
             C_R, 0, 0, 0));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unconsumed", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
